// File: rtl/regfile_write_arbiter_pkg.sv
// Shared types and helpers for the regfile write arbiter.
package regfile_pkg;
  localparam int ADDR_WIDTH = 5;
  localparam int DATA_WIDTH = 32;
  localparam int MAX_REQ    = 8;

  localparam logic [ADDR_WIDTH-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
  } wb_req_t;

  // First set bit of mask scanning from ptr upward, wrapping modulo n.
  // Returns {found, index}.
  function automatic logic [3:0] rr_first(input logic [MAX_REQ-1:0] mask,
                                          input int ptr, input int n);
    logic [3:0] r;
    int         j;
    r = '0;
    // Walk backwards so the last hit written is the nearest to ptr.
    for (int k = MAX_REQ-1; k >= 0; k--) begin
      if (k < n) begin
        j = ptr + k;
        if (j >= n) j = j - n;
        if (mask[j]) r = {1'b1, 3'(j)};
      end
    end
    return r;
  endfunction
endpackage

// File: rtl/regfile_write_arbiter_if.sv
// Writeback request bus and the two regfile write ports.
interface regfile_write_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
);
  logic [NUM_REQ-1:0]                 req_valid;
  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0] req_addr;
  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]                 req_ready;
  logic                               write_enable_a;
  logic [ADDR_WIDTH-1:0]              write_address_a;
  logic [DATA_WIDTH-1:0]              write_data_a;
  logic                               write_enable_b;
  logic [ADDR_WIDTH-1:0]              write_address_b;
  logic [DATA_WIDTH-1:0]              write_data_b;
  logic                               busy;

  modport master (
    output req_valid, req_addr, req_data,
    input  req_ready, busy,
    input  write_enable_a, write_address_a, write_data_a,
    input  write_enable_b, write_address_b, write_data_b
  );

  modport slave (
    input  req_valid, req_addr, req_data,
    output req_ready, busy,
    output write_enable_a, write_address_a, write_data_a,
    output write_enable_b, write_address_b, write_data_b
  );
endinterface

// File: rtl/regfile_write_arbiter_rr_pick2.sv
// Combinational round-robin picker: up to two grants, second one skips
// requesters flagged in the conflict mask (same address as the first).
module rr_pick2
  import regfile_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  localparam int PW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] valid_i,
  input  logic [PW-1:0]      rr_ptr_i,
  input  logic [NUM_REQ-1:0] conflict_i,
  output logic [NUM_REQ-1:0] grant_a_o,
  output logic [NUM_REQ-1:0] grant_b_o,
  output logic [PW-1:0]      idx_a_o,
  output logic [PW-1:0]      idx_b_o,
  output logic               found_a_o,
  output logic               found_b_o
);
  logic [MAX_REQ-1:0] va, vb;
  logic [3:0]         fa, fb;

  // Slot A is the first valid from the pointer; slot B the next valid
  // that is neither slot A nor address-conflicting with it.
  always_comb begin
    va                 = '0;
    va[NUM_REQ-1:0]    = valid_i;
    fa                 = rr_first(va, int'(rr_ptr_i), NUM_REQ);
    found_a_o          = fa[3];
    idx_a_o            = fa[PW-1:0];
    grant_a_o          = '0;
    if (found_a_o) grant_a_o[idx_a_o] = 1'b1;

    vb                 = '0;
    vb[NUM_REQ-1:0]    = valid_i & ~conflict_i & ~grant_a_o;
    fb                 = rr_first(vb, int'(rr_ptr_i), NUM_REQ);
    found_b_o          = fb[3] & found_a_o;
    idx_b_o            = fb[PW-1:0];
    grant_b_o          = '0;
    if (found_b_o) grant_b_o[idx_b_o] = 1'b1;
  end
endmodule

// File: rtl/regfile_write_arbiter.sv
// Two-port regfile write arbiter: round-robin, same-address conflict
// resolution, registered write ports (1-cycle latency), r0 writes dropped.
module regfile_write_arbiter
  import regfile_pkg::rr_first;
  import regfile_pkg::MAX_REQ;
#(
  parameter  int NUM_REQ    = 4,
  parameter  int DATA_WIDTH = regfile_pkg::DATA_WIDTH,
  parameter  int ADDR_WIDTH = regfile_pkg::ADDR_WIDTH,
  localparam int PW         = $clog2(NUM_REQ)
) (
  input logic                    clk,
  input logic                    reset,
  regfile_write_arbiter_if.slave bus
);
  logic [PW-1:0]         rr_ptr_q, rr_ptr_d;
  logic                  we_a_q, we_b_q;
  logic [ADDR_WIDTH-1:0] addr_a_q, addr_b_q;
  logic [DATA_WIDTH-1:0] data_a_q, data_b_q;

  logic [MAX_REQ-1:0]    va;
  logic [3:0]            first;
  logic [NUM_REQ-1:0]    conflict, grant_a, grant_b;
  logic [PW-1:0]         idx_a, idx_b;
  logic                  found_a, found_b;

  // Conflict mask: everyone sharing the address of the slot-A winner.
  always_comb begin
    va              = '0;
    va[NUM_REQ-1:0] = bus.req_valid;
    first           = rr_first(va, int'(rr_ptr_q), NUM_REQ);
    conflict        = '0;
    for (int j = 0; j < NUM_REQ; j++)
      conflict[j] = (bus.req_addr[j] == bus.req_addr[first[PW-1:0]]);
  end

  rr_pick2 #(.NUM_REQ(NUM_REQ)) u_pick (
    .valid_i    (bus.req_valid),
    .rr_ptr_i   (rr_ptr_q),
    .conflict_i (conflict),
    .grant_a_o  (grant_a),
    .grant_b_o  (grant_b),
    .idx_a_o    (idx_a),
    .idx_b_o    (idx_b),
    .found_a_o  (found_a),
    .found_b_o  (found_b)
  );

  // Ready is held low during reset so nothing transfers into a cleared block.
  always_comb begin
    bus.req_ready = reset ? (grant_a | grant_b) : '0;
    bus.busy      = |(bus.req_valid & ~bus.req_ready);
  end

  // Pointer moves just past the last granted requester.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (found_b)
      rr_ptr_d = (int'(idx_b) == NUM_REQ-1) ? '0 : idx_b + 1'b1;
    else if (found_a)
      rr_ptr_d = (int'(idx_a) == NUM_REQ-1) ? '0 : idx_a + 1'b1;
  end

  // Register granted writes; idle slot drops enable but holds addr/data.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rr_ptr_q <= '0;
      we_a_q   <= 1'b0;
      we_b_q   <= 1'b0;
      addr_a_q <= '0;
      addr_b_q <= '0;
      data_a_q <= '0;
      data_b_q <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      we_a_q   <= found_a && (bus.req_addr[idx_a] != '0);
      we_b_q   <= found_b && (bus.req_addr[idx_b] != '0);
      if (found_a) begin
        addr_a_q <= bus.req_addr[idx_a];
        data_a_q <= bus.req_data[idx_a];
      end
      if (found_b) begin
        addr_b_q <= bus.req_addr[idx_b];
        data_b_q <= bus.req_data[idx_b];
      end
    end
  end

  always_comb begin
    bus.write_enable_a  = we_a_q;
    bus.write_address_a = addr_a_q;
    bus.write_data_a    = data_a_q;
    bus.write_enable_b  = we_b_q;
    bus.write_address_b = addr_b_q;
    bus.write_data_b    = data_b_q;
  end
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter (4 requesters, 32b data, 5b addr).
module tb_regfile_write_arbiter;
  import regfile_pkg::*;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  regfile_write_arbiter_if #(.NUM_REQ(4), .DATA_WIDTH(32), .ADDR_WIDTH(5)) bus();

  regfile_write_arbiter #(.NUM_REQ(4), .DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int      checks   = 0;
  int      failures = 0;
  wb_req_t rq [4];

  wire [37:0] pa = {bus.write_enable_a, bus.write_address_a, bus.write_data_a};
  wire [37:0] pb = {bus.write_enable_b, bus.write_address_b, bus.write_data_b};

  task automatic drive(input logic [3:0] v);
    for (int i = 0; i < 4; i++) begin
      bus.req_addr[i] = rq[i].addr;
      bus.req_data[i] = rq[i].data;
    end
    bus.req_valid = v;
  endtask

  task automatic test_reset;
    for (int i = 0; i < 4; i++) rq[i] = '{addr: 5'(i+1), data: 32'h100 + 32'(i)};
    @(negedge clk); drive(4'b1111); #1;
    checks++; if ({bus.req_ready, bus.busy} !== 5'b0000_1) begin failures++;
      $display("FAIL reset_ready got=%b/%b exp=0000/1", bus.req_ready, bus.busy); end
    @(posedge clk); #1;
    checks++; if ({pa, pb} !== 76'd0) begin failures++;
      $display("FAIL reset_outputs got a=%h b=%h exp 0", pa, pb); end
    @(negedge clk); reset = 1'b1; #1;
    checks++; if ({bus.req_ready, bus.busy} !== 5'b0011_1) begin failures++;
      $display("FAIL release_ready got=%b/%b exp=0011/1", bus.req_ready, bus.busy); end
    @(posedge clk); #1;
    checks++; if (pa !== {1'b1, 5'd1, 32'h100} || pb !== {1'b1, 5'd2, 32'h101}) begin failures++;
      $display("FAIL release_ports got a=%h b=%h", pa, pb); end
    @(negedge clk); drive(4'b1100); #1;
    checks++; if ({bus.req_ready, bus.busy} !== 5'b1100_0) begin failures++;
      $display("FAIL release_ready2 got=%b/%b exp=1100/0", bus.req_ready, bus.busy); end
    @(posedge clk); #1;
    checks++; if (pa !== {1'b1, 5'd3, 32'h102} || pb !== {1'b1, 5'd4, 32'h103}) begin failures++;
      $display("FAIL release_ports2 got a=%h b=%h", pa, pb); end
    @(negedge clk); drive(4'b0000);
  endtask

  task automatic test_single;
    rq[2] = '{addr: 5'd7, data: 32'hDEADBEEF};
    @(negedge clk); drive(4'b0100); #1;
    checks++; if ({bus.req_ready, bus.busy} !== 5'b0100_0) begin failures++;
      $display("FAIL single_ready got=%b/%b exp=0100/0", bus.req_ready, bus.busy); end
    @(posedge clk); #1;
    checks++; if (pa !== {1'b1, 5'd7, 32'hDEADBEEF} || pb !== {1'b0, 5'd4, 32'h103}) begin failures++;
      $display("FAIL single_ports got a=%h b=%h", pa, pb); end
    @(negedge clk); drive(4'b0000);
    @(posedge clk); #1;
    checks++; if (pa !== {1'b0, 5'd7, 32'hDEADBEEF}) begin failures++;
      $display("FAIL single_hold got a=%h exp=%h", pa, {1'b0, 5'd7, 32'hDEADBEEF}); end
  endtask

  task automatic test_fairness;
    @(negedge clk); reset = 1'b0; drive(4'b0000);
    @(negedge clk); reset = 1'b1;
    for (int b = 0; b < 2; b++) begin
      for (int i = 0; i < 4; i++)
        rq[i] = '{addr: 5'(10 + 10*b + i), data: 32'h200 + 32'(16*b + i)};
      @(negedge clk); drive(4'b1111); #1;
      checks++; if ({bus.req_ready, bus.busy} !== 5'b0011_1) begin failures++;
        $display("FAIL fair%0d_ready01 got=%b/%b exp=0011/1", b, bus.req_ready, bus.busy); end
      @(posedge clk); #1;
      checks++; if (pa !== {1'b1, 5'(10+10*b), 32'h200 + 32'(16*b)} ||
                    pb !== {1'b1, 5'(11+10*b), 32'h201 + 32'(16*b)}) begin failures++;
        $display("FAIL fair%0d_ports01 got a=%h b=%h", b, pa, pb); end
      @(negedge clk); drive(4'b1100); #1;
      checks++; if ({bus.req_ready, bus.busy} !== 5'b1100_0) begin failures++;
        $display("FAIL fair%0d_ready23 got=%b/%b exp=1100/0", b, bus.req_ready, bus.busy); end
      @(posedge clk); #1;
      checks++; if (pa !== {1'b1, 5'(12+10*b), 32'h202 + 32'(16*b)} ||
                    pb !== {1'b1, 5'(13+10*b), 32'h203 + 32'(16*b)}) begin failures++;
        $display("FAIL fair%0d_ports23 got a=%h b=%h", b, pa, pb); end
    end
    @(negedge clk); drive(4'b0000);
  endtask

  task automatic test_conflict;
    rq[0] = '{addr: 5'd5, data: 32'h500};
    rq[1] = '{addr: 5'd5, data: 32'h501};
    rq[2] = '{addr: 5'd9, data: 32'h502};
    @(negedge clk); drive(4'b0111); #1;
    checks++; if ({bus.req_ready, bus.busy} !== 5'b0101_1) begin failures++;
      $display("FAIL conflict_ready got=%b/%b exp=0101/1", bus.req_ready, bus.busy); end
    @(posedge clk); #1;
    checks++; if (pa !== {1'b1, 5'd5, 32'h500} || pb !== {1'b1, 5'd9, 32'h502}) begin failures++;
      $display("FAIL conflict_ports got a=%h b=%h", pa, pb); end
    @(negedge clk); drive(4'b0010); #1;
    checks++; if ({bus.req_ready, bus.busy} !== 5'b0010_0) begin failures++;
      $display("FAIL conflict_ready2 got=%b/%b exp=0010/0", bus.req_ready, bus.busy); end
    @(posedge clk); #1;
    checks++; if (pa !== {1'b1, 5'd5, 32'h501} || pb !== {1'b0, 5'd9, 32'h502}) begin failures++;
      $display("FAIL conflict_ports2 got a=%h b=%h", pa, pb); end
    @(negedge clk); drive(4'b0000);
  endtask

  task automatic test_r0;
    rq[3] = '{addr: 5'd0, data: 32'h600};
    @(negedge clk); drive(4'b1000); #1;
    checks++; if ({bus.req_ready, bus.busy} !== 5'b1000_0) begin failures++;
      $display("FAIL r0_ready got=%b/%b exp=1000/0", bus.req_ready, bus.busy); end
    @(posedge clk); #1;
    checks++; if (pa !== {1'b0, 5'd0, 32'h600} || pb !== {1'b0, 5'd9, 32'h502}) begin failures++;
      $display("FAIL r0_ports got a=%h b=%h", pa, pb); end
    @(negedge clk); drive(4'b0000);
  endtask

  task automatic test_reset_mid;
    rq[2] = '{addr: 5'd3, data: 32'h700};
    @(negedge clk); drive(4'b0100);
    @(posedge clk); #1;
    checks++; if (pa !== {1'b1, 5'd3, 32'h700}) begin failures++;
      $display("FAIL mid_pre_port got a=%h", pa); end
    rq[3] = '{addr: 5'd6, data: 32'h803};
    rq[0] = '{addr: 5'd7, data: 32'h800};
    rq[1] = '{addr: 5'd8, data: 32'h801};
    @(negedge clk); drive(4'b1011); #1;
    checks++; if ({bus.req_ready, bus.busy} !== 5'b1001_1) begin failures++;
      $display("FAIL mid_ready got=%b/%b exp=1001/1", bus.req_ready, bus.busy); end
    @(posedge clk); #1;
    checks++; if (pa !== {1'b1, 5'd6, 32'h803} || pb !== {1'b1, 5'd7, 32'h800}) begin failures++;
      $display("FAIL mid_ports got a=%h b=%h", pa, pb); end
    @(negedge clk); reset = 1'b0; drive(4'b0010); #1;
    checks++; if ({bus.req_ready, bus.busy} !== 5'b0000_1) begin failures++;
      $display("FAIL mid_rst_ready got=%b/%b exp=0000/1", bus.req_ready, bus.busy); end
    @(posedge clk); #1;
    checks++; if ({pa, pb} !== 76'd0) begin failures++;
      $display("FAIL mid_rst_ports got a=%h b=%h exp 0", pa, pb); end
    @(negedge clk); reset = 1'b1; #1;
    checks++; if ({bus.req_ready, bus.busy} !== 5'b0010_0) begin failures++;
      $display("FAIL mid_rel_ready got=%b/%b exp=0010/0", bus.req_ready, bus.busy); end
    @(posedge clk); #1;
    checks++; if (pa !== {1'b1, 5'd8, 32'h801} || pb !== 38'd0) begin failures++;
      $display("FAIL mid_rel_ports got a=%h b=%h", pa, pb); end
    @(negedge clk); drive(4'b0000);
  endtask

  initial begin
    bus.req_valid = '0;
    bus.req_addr  = '0;
    bus.req_data  = '0;
    test_reset();
    test_single();
    test_fairness();
    test_conflict();
    test_r0();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
